// File: rtl/firmware_config_tx.sv
// firmware_config_tx
//   Transmit side of the configId/configData firmware bus. Host write
//   commands are queued in a small FIFO. Each command goes out on the bus
//   as a fixed frame: HDR, CHN, DAT [, PAR], followed by one GAP beat.
//   New frames are held off while tracing is high, so chain firmware never
//   changes in the middle of a trace. A frame that has already left IDLE/GAP
//   always runs to completion.
//
//   Optional build macro: CONFIG_PARITY_EN
//     When defined, a PAR beat follows DAT and frame_done moves to PAR.
//
// Ports
//   clk            clock
//   reset          synchronous, active-high reset
//   tracing        high while tracing; blocks new frames
//   cmd_valid      host command valid
//   cmd_ready      FIFO not full (registered)
//   cmd_target_id  destination block ID
//   cmd_field      field code (0 op, 1 addr_rd, 2 cond, 3 cache, 4 cache_addr)
//   cmd_chain      destination chain index
//   cmd_data       firmware value
//   configId       bus target ID; IDLE_ID when no frame is in flight
//   configData     bus payload byte
//   frame_done     one-cycle pulse on the last beat of each frame
//   busy           FIFO non-empty or a frame in flight
//
// state | meaning
// IDLE  | bus idle, waiting for a queued command with tracing low
// HDR   | header beat: field code
// CHN   | chain index beat
// DAT   | firmware data beat
// PAR   | parity beat (parity builds only)
// GAP   | one idle beat between frames; may launch the next frame directly
module firmware_config_tx #(
  parameter int         MAX_CHAINS     = 4,
  parameter int         CMD_FIFO_DEPTH = 8,
  parameter logic [7:0] IDLE_ID        = 8'hFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tracing,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [7:0]                    cmd_target_id,
  input  logic [2:0]                    cmd_field,
  input  logic [$clog2(MAX_CHAINS)-1:0] cmd_chain,
  input  logic [7:0]                    cmd_data,
  output logic [7:0]                    configId,
  output logic [7:0]                    configData,
  output logic                          frame_done,
  output logic                          busy
);

  localparam int CW = $clog2(MAX_CHAINS);
  localparam int AW = $clog2(CMD_FIFO_DEPTH);
  localparam int EW = 8 + 3 + CW + 8;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(CMD_FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_CHN,
    S_DAT,
    S_PAR,
    S_GAP
  } state_t;

  // ---------------- command FIFO ----------------
  logic [EW-1:0] mem [CMD_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic          push, pop, fifo_empty;

  logic [7:0]    head_target, head_data;
  logic [2:0]    head_field;
  logic [CW-1:0] head_chain;

  assign push       = cmd_valid && cmd_ready;
  assign fifo_empty = (count == '0);
  assign {head_target, head_field, head_chain, head_data} = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (!push && pop)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {cmd_target_id, cmd_field, cmd_chain, cmd_data};
  end

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      cmd_ready <= (count_next != FULL_CNT);
    end
  end

  // ---------------- frame FSM ----------------
  state_t        state, state_next;
  logic [7:0]    f_target, f_data, f_chain_zx, f_parity;
  logic [2:0]    f_field;
  logic [CW-1:0] f_chain;
  logic          launch_ok;
  logic [7:0]    id_d, data_d;
  logic          done_d;

  assign launch_ok  = !fifo_empty && !tracing;
  assign f_chain_zx = 8'(f_chain);
  assign f_parity   = f_target ^ {5'b0, f_field} ^ f_chain_zx ^ f_data;

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // The popped head is latched here so the frame is immune to later pushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_target <= '0;
      f_field  <= '0;
      f_chain  <= '0;
      f_data   <= '0;
    end else if (pop) begin
      f_target <= head_target;
      f_field  <= head_field;
      f_chain  <= head_chain;
      f_data   <= head_data;
    end
  end

  // Bus values are decoded from the current state and then registered,
  // so the bus trails the state register by one cycle.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    id_d       = IDLE_ID;
    data_d     = 8'h00;
    done_d     = 1'b0;
    case (state)
      S_IDLE: begin
        if (launch_ok) begin
          pop        = 1'b1;
          state_next = S_HDR;
        end
      end
      S_HDR: begin
        id_d       = f_target;
        data_d     = {5'b0, f_field};
        state_next = S_CHN;
      end
      S_CHN: begin
        id_d       = f_target;
        data_d     = f_chain_zx;
        state_next = S_DAT;
      end
      S_DAT: begin
        id_d   = f_target;
        data_d = f_data;
`ifdef CONFIG_PARITY_EN
        state_next = S_PAR;
`else
        done_d     = 1'b1;
        state_next = S_GAP;
`endif
      end
`ifdef CONFIG_PARITY_EN
      S_PAR: begin
        id_d       = f_target;
        data_d     = f_parity;
        done_d     = 1'b1;
        state_next = S_GAP;
      end
`endif
      S_GAP: begin
        if (launch_ok) begin
          pop        = 1'b1;
          state_next = S_HDR;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      configId   <= IDLE_ID;
      configData <= 8'h00;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      configId   <= id_d;
      configData <= data_d;
      frame_done <= done_d;
      busy       <= !fifo_empty || (state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_firmware_config_tx.sv
module tb_firmware_config_tx;

  localparam logic [7:0] IDLE = 8'hFF;
`ifdef CONFIG_PARITY_EN
  localparam logic DAT_DONE = 1'b0;
`else
  localparam logic DAT_DONE = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       tracing;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_target_id;
  logic [2:0] cmd_field;
  logic [1:0] cmd_chain;
  logic [7:0] cmd_data;
  logic [7:0] configId;
  logic [7:0] configData;
  logic       frame_done;
  logic       busy;

  int errors = 0;
  int checks = 0;

  firmware_config_tx dut (
    .clk           (clk),
    .reset         (reset),
    .tracing       (tracing),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_target_id (cmd_target_id),
    .cmd_field     (cmd_field),
    .cmd_chain     (cmd_chain),
    .cmd_data      (cmd_data),
    .configId      (configId),
    .configData    (configData),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [7:0] id, input logic [7:0] data,
                      input logic done);
    chk({tag, " id"}, configId, id);
    chk({tag, " data"}, configData, data);
    chk({tag, " done"}, {7'b0, frame_done}, {7'b0, done});
  endtask

  task automatic drive(input logic [7:0] t, input logic [2:0] f, input logic [1:0] c,
                       input logic [7:0] d);
    cmd_valid     = 1'b1;
    cmd_target_id = t;
    cmd_field     = f;
    cmd_chain     = c;
    cmd_data      = d;
  endtask

  // Expects the bus to show HDR on the next edge.
  task automatic check_frame(input string tag, input logic [7:0] t, input logic [2:0] f,
                             input logic [1:0] c, input logic [7:0] d);
    tick(); beat({tag, " hdr"}, t, {5'b0, f}, 1'b0);
    tick(); beat({tag, " chn"}, t, {6'b0, c}, 1'b0);
    tick(); beat({tag, " dat"}, t, d, DAT_DONE);
`ifdef CONFIG_PARITY_EN
    tick(); beat({tag, " par"}, t, t ^ {5'b0, f} ^ {6'b0, c} ^ d, 1'b1);
`endif
    tick(); beat({tag, " gap"}, IDLE, 8'h00, 1'b0);
  endtask

  initial begin
    reset = 1'b1; tracing = 1'b0; cmd_valid = 1'b0;
    cmd_target_id = '0; cmd_field = '0; cmd_chain = '0; cmd_data = '0;

    // reset then idle
    tick(); tick();
    beat("reset", IDLE, 8'h00, 1'b0);
    chk("reset busy", {7'b0, busy}, 8'd0);
    chk("reset ready", {7'b0, cmd_ready}, 8'd1);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      beat("idle", IDLE, 8'h00, 1'b0);
      chk("idle busy", {7'b0, busy}, 8'd0);
      chk("idle ready", {7'b0, cmd_ready}, 8'd1);
    end

    // single write, HDR two edges after acceptance
    drive(8'h03, 3'd1, 2'd2, 8'h05);
    tick();
    cmd_valid = 1'b0;
    chk("single lat0 id", configId, IDLE);
    tick();
    chk("single lat1 id", configId, IDLE);
    chk("single busy", {7'b0, busy}, 8'd1);
    check_frame("single", 8'h03, 3'd1, 2'd2, 8'h05);
    tick();
    chk("single end busy", {7'b0, busy}, 8'd0);
    chk("single end id", configId, IDLE);

    // FIFO full / backpressure under tracing
    tracing = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("fill ready", {7'b0, cmd_ready}, (i < 8) ? 8'd1 : 8'd0);
      drive(8'h40, 3'd2, 2'd1, 8'(i));
      tick();
      chk("fill id", configId, IDLE);
    end
    cmd_valid = 1'b0;
    tick();
    chk("full ready", {7'b0, cmd_ready}, 8'd0);
    chk("full busy", {7'b0, busy}, 8'd1);
    chk("full id", configId, IDLE);
    tracing = 1'b0;
    tick();
    chk("launch id", configId, IDLE);
    for (int i = 0; i < 8; i++)
      check_frame("drain", 8'h40, 3'd2, 2'd1, 8'(i));
    tick();
    beat("drain end", IDLE, 8'h00, 1'b0);
    chk("drain busy", {7'b0, busy}, 8'd0);
    chk("drain ready", {7'b0, cmd_ready}, 8'd1);

    // tracing raised mid-frame
    drive(8'h05, 3'd0, 2'd3, 8'h11);
    tick();
    drive(8'h06, 3'd4, 2'd0, 8'h22);
    tick();
    cmd_valid = 1'b0;
    tick(); beat("midtr hdr", 8'h05, 8'h00, 1'b0);
    tick(); beat("midtr chn", 8'h05, 8'h03, 1'b0);
    tracing = 1'b1;
    tick(); beat("midtr dat", 8'h05, 8'h11, DAT_DONE);
`ifdef CONFIG_PARITY_EN
    tick(); beat("midtr par", 8'h05, 8'h05 ^ 8'h00 ^ 8'h03 ^ 8'h11, 1'b1);
`endif
    tick(); beat("midtr gap", IDLE, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      beat("midtr hold", IDLE, 8'h00, 1'b0);
      chk("midtr hold busy", {7'b0, busy}, 8'd1);
    end
    tracing = 1'b0;
    tick();
    chk("midtr decide id", configId, IDLE);
    check_frame("midtr next", 8'h06, 3'd4, 2'd0, 8'h22);
    tick();
    chk("midtr busy", {7'b0, busy}, 8'd0);

    // reset during DAT with 3 entries queued
    drive(8'h07, 3'd1, 2'd1, 8'h30);
    tick();
    drive(8'h08, 3'd1, 2'd1, 8'h31);
    tick();
    drive(8'h09, 3'd1, 2'd1, 8'h32);
    tick();
    beat("rst hdr", 8'h07, 8'h01, 1'b0);
    drive(8'h0A, 3'd1, 2'd1, 8'h33);
    tick();
    beat("rst chn", 8'h07, 8'h01, 1'b0);
    cmd_valid = 1'b0;
    tick();
    beat("rst dat", 8'h07, 8'h30, DAT_DONE);
    reset = 1'b1;
    tick();
    beat("rst abort", IDLE, 8'h00, 1'b0);
    chk("rst busy", {7'b0, busy}, 8'd0);
    chk("rst ready", {7'b0, cmd_ready}, 8'd1);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      beat("post rst", IDLE, 8'h00, 1'b0);
      chk("post rst busy", {7'b0, busy}, 8'd0);
    end

`ifdef CONFIG_PARITY_EN
    drive(8'h10, 3'd3, 2'd1, 8'hA5);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick(); beat("par hdr", 8'h10, 8'h03, 1'b0);
    tick(); beat("par chn", 8'h10, 8'h01, 1'b0);
    tick(); beat("par dat", 8'h10, 8'hA5, 1'b0);
    tick(); beat("par par", 8'h10, 8'hB7, 1'b1);
    tick(); beat("par gap", IDLE, 8'h00, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
